// File: rtl/lfsr_stream_if.sv
// Register-write bus and valid/ready stream bundle for the LFSR stream engine.
// The engine connects through the slave modport; the driver side uses master.
interface lfsr_stream_if #(
  parameter int STEP = 10
) ();
  logic            write;
  logic [11:0]     addr;
  logic [31:0]     wdata;
  logic            s_valid;
  logic            s_ready;
  logic [STEP-1:0] s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [STEP-1:0] m_data;
  logic            m_last;

  modport master (
    output write, addr, wdata,
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  write, addr, wdata,
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/lfsr_stream_engine.sv
// Galois LFSR stream engine: STEP bits per beat in CRC or additive-scramble mode.
// Seed and control arrive on the register bus; one registered output stage.
module lfsr_stream_engine #(
  parameter int               LFSR_W    = 64,
  parameter logic [LFSR_W-1:0] POLY     = 64'h42F0_E1EB_A9EA_3693,
  parameter int               STEP      = 10,
  parameter logic [11:0]      ADDR_BASE = 12'h068
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_stream_if.slave      bus,
  output logic [LFSR_W-1:0] state_o
);

  localparam int          NW        = LFSR_W / 32;
  localparam logic [11:0] CTRL_ADDR = ADDR_BASE + 12'(NW);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] seed;
  logic [LFSR_W-1:0] nxt;
  logic [STEP-1:0]   dout;
  logic [STEP-1:0]   m_data_q;
  logic              m_last_q;
  logic              m_valid_q;
  logic              mode;
  logic              auto_reseed;
  logic              ctrl_wr;
  logic              load;
  logic              accept;
  logic              reseed;

  assign bus.s_ready = ~m_valid_q | bus.m_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign state_o     = state;

  assign ctrl_wr = bus.write && (bus.addr == CTRL_ADDR);
  assign load    = ctrl_wr && bus.wdata[3];
  assign accept  = bus.s_valid && bus.s_ready;
  assign reseed  = accept && bus.s_last && auto_reseed;

  // Bit 0 of the tap mask is forced to 1 so n[0] always carries msb.
  always_comb begin : step_chain
    logic [LFSR_W-1:0] s;
    logic              msb;
    s    = state;
    msb  = 1'b0;
    dout = '0;
    for (int i = 0; i < STEP; i++) begin
      msb     = s[LFSR_W-1];
      dout[i] = mode ? (bus.s_data[i] ^ msb) : bus.s_data[i];
      s       = {s[LFSR_W-2:0], 1'b0}
              ^ ({LFSR_W{msb}} & {POLY[LFSR_W-1:1], 1'b1});
      s[0]    = s[0] ^ (~mode & bus.s_data[i]);
    end
    nxt = s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= '0;
      seed        <= '0;
      mode        <= 1'b0;
      auto_reseed <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (bus.write && (bus.addr == ADDR_BASE + 12'(k)))
          seed[32*k +: 32] <= bus.wdata;
      end

      if (ctrl_wr) begin
        mode        <= bus.wdata[0];
        auto_reseed <= bus.wdata[2];
      end

      if (load)
        state <= seed;
      else if (reseed)
        state <= seed;
      else if (accept)
        state <= nxt;

      if (accept) begin
        m_data_q  <= dout;
        m_last_q  <= bus.s_last;
        m_valid_q <= 1'b1;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_engine.sv
// Bench for lfsr_stream_engine: per-cycle model compare plus literal pins,
// with a STEP=1 instance for single-step feedback checks.
module tb_lfsr_stream_engine;

  localparam logic [63:0] POLY = 64'h42F0_E1EB_A9EA_3693;
  localparam logic [11:0] SEED0 = 12'h068;
  localparam logic [11:0] SEED1 = 12'h069;
  localparam logic [11:0] CTRL  = 12'h06A;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] st0;
  logic [63:0] st1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lfsr_stream_if #(.STEP(10)) b0 ();
  lfsr_stream_if #(.STEP(1))  b1 ();

  lfsr_stream_engine #(
    .LFSR_W(64), .POLY(POLY), .STEP(10), .ADDR_BASE(12'h068)
  ) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave), .state_o(st0)
  );

  lfsr_stream_engine #(
    .LFSR_W(64), .POLY(POLY), .STEP(1), .ADDR_BASE(12'h068)
  ) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .state_o(st1)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One LFSR bit as polynomial arithmetic: multiply by x, reduce, add d.
  function automatic logic [63:0] adv(input logic [63:0] s, input logic d);
    logic [63:0] r;
    r = s << 1;
    if (s[63]) r = r ^ POLY;
    r[0] = r[0] ^ d;
    return r;
  endfunction

  logic [63:0] e_state, e_seed;
  logic        e_mode, e_auto;
  logic        e_valid, e_last;
  logic [9:0]  e_data;
  logic        live = 1'b0;

  always @(posedge clk) begin : model
    logic        acc, ld;
    logic [63:0] s, nseed, nstate;
    logic [9:0]  o;
    if (rst) begin
      e_state <= '0; e_seed <= '0; e_mode <= 1'b0; e_auto <= 1'b0;
      e_valid <= 1'b0; e_last <= 1'b0; e_data <= '0;
      live    <= 1'b1;
    end else if (live) begin
      acc    = b0.s_valid && (!e_valid || b0.m_ready);
      ld     = b0.write && (b0.addr == CTRL) && b0.wdata[3];
      nstate = e_state;
      if (acc) begin
        s = e_state;
        o = '0;
        for (int i = 0; i < 10; i++) begin
          o[i] = e_mode ? (b0.s_data[i] ^ s[63]) : b0.s_data[i];
          s    = adv(s, e_mode ? 1'b0 : b0.s_data[i]);
        end
        nstate  = (b0.s_last && e_auto) ? e_seed : s;
        e_data  <= o;
        e_last  <= b0.s_last;
        e_valid <= 1'b1;
      end else if (b0.m_ready) begin
        e_valid <= 1'b0;
      end
      if (ld) nstate = e_seed;
      e_state <= nstate;
      nseed = e_seed;
      if (b0.write && b0.addr == SEED0) nseed[31:0]  = b0.wdata;
      if (b0.write && b0.addr == SEED1) nseed[63:32] = b0.wdata;
      e_seed <= nseed;
      if (b0.write && b0.addr == CTRL) begin
        e_mode <= b0.wdata[0];
        e_auto <= b0.wdata[2];
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("state_o", st0, e_state);
      chk("m_valid", 64'(b0.m_valid), 64'(e_valid));
      chk("s_ready", 64'(b0.s_ready), 64'(!e_valid || b0.m_ready));
      if (e_valid) begin
        chk("m_data", 64'(b0.m_data), 64'(e_data));
        chk("m_last", 64'(b0.m_last), 64'(e_last));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    b0.write = 1'b1; b0.addr = a; b0.wdata = d;
    cyc();
    b0.write = 1'b0;
  endtask

  task automatic beat(input logic [9:0] d, input logic last);
    b0.s_valid = 1'b1; b0.s_data = d; b0.s_last = last;
    cyc();
    b0.s_valid = 1'b0; b0.s_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    b0.write = 0; b0.addr = '0; b0.wdata = '0;
    b0.s_valid = 0; b0.s_data = '0; b0.s_last = 0; b0.m_ready = 1;
    b1.write = 0; b1.addr = '0; b1.wdata = '0;
    b1.s_valid = 0; b1.s_data = '0; b1.s_last = 0; b1.m_ready = 1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("reset_state", st0, 64'h0);
    chk("reset_m_valid", 64'(b0.m_valid), 64'h0);

    // STEP=1 instance: msb feedback applies the full tap mask
    b1.write = 1; b1.addr = SEED1; b1.wdata = 32'h8000_0000;
    cyc();
    b1.addr = CTRL; b1.wdata = 32'h8;
    cyc();
    b1.write = 0;
    b1.s_valid = 1; b1.s_data = 1'b0;
    cyc();
    chk("step1_state", st1, 64'h42F0_E1EB_A9EA_3693);
    b1.s_data = 1'b1;
    cyc();
    b1.s_valid = 0;
    chk("step1_state2", st1, 64'h85E1_C3D7_53D4_6D27);

    // CRC from seed 0
    wr(CTRL, 32'h8);
    beat(10'h001, 1'b0);
    chk("crc_m_data", 64'(b0.m_data), 64'h001);
    chk("crc_state", st0, 64'h200);
    cyc();

    // additive scramble from seed 1, then from seed 0
    wr(SEED0, 32'h1);
    wr(SEED1, 32'h0);
    wr(CTRL, 32'h9);
    beat(10'h3A5, 1'b0);
    chk("add_m_data", 64'(b0.m_data), 64'h3A5);
    chk("add_state", st0, 64'h400);
    wr(SEED0, 32'h0);
    wr(CTRL, 32'h9);
    beat(10'h155, 1'b0);
    chk("add0_m_data", 64'(b0.m_data), 64'h155);
    chk("add0_state", st0, 64'h0);

    // backpressure hold
    wr(CTRL, 32'h8);
    b0.m_ready = 0;
    b0.s_valid = 1; b0.s_data = 10'h2AB;
    cyc();
    b0.s_data = 10'h0F0;
    repeat (5) begin
      cyc();
      chk("hold_s_ready", 64'(b0.s_ready), 64'h0);
      chk("hold_m_data", 64'(b0.m_data), 64'h2AB);
      chk("hold_state", st0, 64'h355);
    end
    b0.s_valid = 0; b0.m_ready = 1;
    cyc();
    chk("release_m_valid", 64'(b0.m_valid), 64'h0);
    chk("release_state", st0, 64'h355);

    // auto reseed on last beat
    wr(SEED0, 32'h1234);
    wr(CTRL, 32'h4);
    beat(10'h3FF, 1'b1);
    chk("reseed_m_last", 64'(b0.m_last), 64'h1);
    chk("reseed_m_data", 64'(b0.m_data), 64'h3FF);
    chk("reseed_state", st0, 64'h1234);
    cyc();

    // scramble with the msb set, then load strobe on a beat
    wr(SEED1, 32'h8000_0000);
    wr(SEED0, 32'h0);
    wr(CTRL, 32'h9);
    beat(10'h0C3, 1'b0);
    beat(10'h2F1, 1'b0);
    b0.write = 1; b0.addr = CTRL; b0.wdata = 32'h8;
    beat(10'h123, 1'b0);
    b0.write = 0;
    chk("load_beat_state", st0, 64'h8000_0000_0000_0000);

    // streaming with mixed valid, last and ready patterns in both modes
    for (int m = 0; m < 2; m++) begin
      wr(CTRL, (m == 0) ? 32'h4 : 32'h5);
      for (int i = 0; i < 24; i++) begin
        b0.s_valid = (i % 4) != 3;
        b0.s_data  = 10'(i * 37 + 5 + m * 101);
        b0.s_last  = (i % 6) == 5;
        b0.m_ready = (i % 5) != 2;
        cyc();
      end
      b0.s_valid = 0; b0.s_last = 0; b0.m_ready = 1;
      cyc();
    end

    // reset while output is valid; seed write under reset is dropped
    b0.m_ready = 0;
    beat(10'h0AA, 1'b0);
    chk("pre_rst_m_valid", 64'(b0.m_valid), 64'h1);
    rst = 1;
    b0.write = 1; b0.addr = SEED1; b0.wdata = 32'hDEAD;
    cyc();
    chk("rst_m_valid", 64'(b0.m_valid), 64'h0);
    chk("rst_state", st0, 64'h0);
    rst = 0; b0.write = 0; b0.m_ready = 1;
    wr(CTRL, 32'h8);
    chk("rst_seed_dropped", st0, 64'h0);
    beat(10'h001, 1'b0);
    chk("rst_mode_crc", st0, 64'h200);
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
